mem_access_ctrl: RTL

- Sequencer between the 8051 core execute stage and the data/xdata memory block.
- Accepts one memory request at a time from the core over a valid/ready handshake.
- Drives the memory block's read/write enables, addresses and write data, then returns a single response to the core.
- Supports direct reads and writes to data and xdata space, plus read-modify-write bit operations (SETB/CLR/CPL) on data space, with a read timeout.

---
 rtl/mem_access_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one core memory request at a time onto the data/xdata memory block
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake; req_op, req_addr, req_wdata, req_bit describe it
//   resp_valid/resp_ready         response handshake; resp_data, resp_err carry the result
//   rd_addr, data_rd_en, xdata_rd_en, rd_data, rd_vld      memory read side
//   wr_addr, wr_data, data_wr_en, xdata_wr_en              memory write side
module mem_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [2:0]  req_bit,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_data,
    output logic        resp_err,
    output logic [15:0] rd_addr,
    output logic        data_rd_en,
    output logic        xdata_rd_en,
    input  logic [7:0]  rd_data,
    input  logic        rd_vld,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        data_wr_en,
    output logic        xdata_wr_en
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t           state;
    logic [2:0]       op_q;
    logic [2:0]       bit_q;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      addr_eff;
    logic [7:0]       mask;
    logic [7:0]       mod_byte;
    always_comb begin
        // data space only decodes the low byte; the upper byte goes out as zero
        addr_eff = (req_op == 3'd1 || req_op == 3'd3) ? req_addr : {8'h00, req_addr[7:0]};
        mask     = 8'd1 << bit_q;
        mod_byte = (op_q == 3'd4) ? (rd_data | mask) : (op_q == 3'd5) ? (rd_data & ~mask) : (rd_data ^ mask);
    end
    assign req_ready = (state == IDLE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            bit_q       <= '0;
            cnt         <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_data   <= '0;
            rd_addr     <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            data_rd_en  <= 1'b0;
            xdata_rd_en <= 1'b0;
            data_wr_en  <= 1'b0;
            xdata_wr_en <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q      <= req_op;
                    bit_q     <= req_bit;
                    cnt       <= '0;
                    rd_addr   <= addr_eff;
                    wr_addr   <= addr_eff;
                    wr_data   <= req_wdata;
                    resp_data <= req_wdata;
                    resp_err  <= 1'b0;
                    if (req_op == 3'd7) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= 8'hFF;
                    end else if (req_op == 3'd2 || req_op == 3'd3) begin
                        state       <= WRITE;
                        data_wr_en  <= (req_op == 3'd2);
                        xdata_wr_en <= (req_op == 3'd3);
                    end else begin
                        state       <= READ;
                        data_rd_en  <= (req_op != 3'd1);
                        xdata_rd_en <= (req_op == 3'd1);
                    end
                end
                READ: begin
                    // cnt == 0 marks the first READ cycle, where rd_vld may still be stale
                    if (cnt != '0 && rd_vld) begin
                        data_rd_en  <= 1'b0;
                        xdata_rd_en <= 1'b0;
                        resp_data   <= rd_data;
                        if (op_q[2]) begin
                            state      <= WRITE;
                            wr_data    <= mod_byte;
                            data_wr_en <= 1'b1;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        data_rd_en  <= 1'b0;
                        xdata_rd_en <= 1'b0;
                        state       <= RESP;
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b1;
                        resp_data   <= 8'hFF;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    data_wr_en  <= 1'b0;
                    xdata_wr_en <= 1'b0;
                    state       <= RESP;
                    resp_valid  <= 1'b1;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
